// File: rtl/csa_serial_adder_ctrl.sv
// Digit-serial wide adder: operands are latched on accept, then one DIGIT-wide
// carry-select slice is summed per cycle while the inter-digit carry is kept in a register.
module csa_serial_adder_ctrl #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N  = WIDTH / DIGIT;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] opa, opb;
    logic [DIGIT-1:0] a_d, b_d;
    logic [DIGIT:0]   s0, s1, sel;
    logic             accept;

    assign accept = in_valid && in_ready;

    // Both carry-in outcomes are formed up front; the registered carry only drives the select.
    always_comb begin
        a_d = opa[idx*DIGIT +: DIGIT];
        b_d = opb[idx*DIGIT +: DIGIT];
        s0  = {1'b0, a_d} + {1'b0, b_d};
        s1  = {1'b0, a_d} + {1'b0, b_d} + (DIGIT+1)'(1);
        sel = carry ? s1 : s0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (idx == LAST) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // in_ready is gated by rst so nothing can be accepted while reset is held.
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        idx   <= '0;
                        sum   <= '0;
                    end
                end
                RUN: begin
                    sum[idx*DIGIT +: DIGIT] <= sel[DIGIT-1:0];
                    carry                   <= sel[DIGIT];
                    idx                     <= idx + IW'(1);
                    if (idx == LAST) begin
                        cout <= sel[DIGIT];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_serial_adder_ctrl.sv
// Self-checking bench for csa_serial_adder_ctrl: directed table, backpressure, mid-op reset,
// randomized operands against an arithmetic reference, plus an 8-bit instance.
module tb_csa_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [31:0] a, b, sum;

    logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
    logic [7:0]  a8, b8, sum8;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic        co;
    } vec_t;

    always #5 clk = ~clk;

    csa_serial_adder_ctrl #(.WIDTH(32), .DIGIT(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    csa_serial_adder_ctrl #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_in_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic wait_out_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    // Full operation on the 32-bit instance; expected values come from the caller.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                         input logic [31:0] es, input logic ec, input int hold);
        int lat;
        wait_in_ready();
        in_valid = 1'b1; a = ta; b = tb; cin = tc;
        tick();
        in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom);
        check("in_ready_run", 64'(in_ready), 64'd0);
        wait_out_valid(lat);
        check("latency", 64'(lat), 64'd16);
        check("sum", 64'(sum), 64'(es));
        check("cout", 64'(cout), 64'(ec));
        for (int i = 0; i < hold; i++) tick();
        if (hold > 0) check("sum_held", 64'(sum), 64'(es));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_drop", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        vec_t t8[3];
        logic [32:0] ref_full;
        logic [8:0]  ref8;
        int lat;

        tbl[0] = '{32'h00000002, 32'h00000001, 1'b0, 32'h00000003, 1'b0};
        tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        tbl[2] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
        tbl[3] = '{32'h5A5A5A5A, 32'hA5A5A5A5, 1'b0, 32'hFFFFFFFF, 1'b0};
        t8[0]  = '{32'h80, 32'h80, 1'b0, 32'h00, 1'b1};
        t8[1]  = '{32'h7F, 32'h01, 1'b1, 32'h81, 1'b0};
        t8[2]  = '{32'hFF, 32'hFF, 1'b1, 32'hFF, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        tick(); tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 4; i++)
            do_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, 0);

        // Backpressure with a second operand pending the whole time.
        wait_in_ready();
        in_valid = 1'b1; a = 32'h12345678; b = 32'h11111111; cin = 1'b0;
        tick();
        a = 32'h00000007; b = 32'h00000008;
        wait_out_valid(lat);
        check("bp_latency", 64'(lat), 64'd16);
        for (int i = 0; i < 5; i++) begin
            check("bp_sum", 64'(sum), 64'h23456789);
            check("bp_cout", 64'(cout), 64'd0);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp_second_taken", 64'(in_ready), 64'd0);
        wait_out_valid(lat);
        check("bp_second_lat", 64'(lat), 64'd16);
        check("bp_second_sum", 64'(sum), 64'd15);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset while idx==7; sum already holds written ones.
        wait_in_ready();
        in_valid = 1'b1; a = 32'hFFFFFFFF; b = 32'h0; cin = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("mid_not_done", 64'(out_valid), 64'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_sum", 64'(sum), 64'd0);
        check("mid_rst_cout", 64'(cout), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(in_ready), 64'd1);
        do_op(32'd3, 32'd1, 1'b0, 32'd4, 1'b0, 0);

        // Random operands against plain arithmetic.
        for (int i = 0; i < 20; i++) begin
            logic [31:0] ra, rb;
            logic        rc;
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            if (i == 0) ra = 32'hFFFFFFFF;
            ref_full = {1'b0, ra} + {1'b0, rb} + 33'(rc);
            do_op(ra, rb, rc, ref_full[31:0], ref_full[32], $urandom_range(0, 3));
        end

        // 8-bit instance: N=4.
        for (int i = 0; i < 3; i++) begin
            ref8 = {1'b0, t8[i].a[7:0]} + {1'b0, t8[i].b[7:0]} + 9'(t8[i].cin);
            check("w8_model", 64'(ref8), 64'({t8[i].co, t8[i].s[7:0]}));
            check("w8_ready", 64'(in_ready8), 64'd1);
            in_valid8 = 1'b1; a8 = t8[i].a[7:0]; b8 = t8[i].b[7:0]; cin8 = t8[i].cin;
            tick();
            in_valid8 = 1'b0;
            lat = 0;
            while (!out_valid8 && lat < 50) begin
                tick();
                lat++;
            end
            check("w8_latency", 64'(lat), 64'd4);
            check("w8_sum", 64'(sum8), 64'(t8[i].s[7:0]));
            check("w8_cout", 64'(cout8), 64'(t8[i].co));
            out_ready8 = 1'b1;
            tick();
            out_ready8 = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
